// File: rtl/serial_add_sequencer.sv
// Bit-serial N-bit adder controller. One full-adder slice, built from two half adders,
// is reused LSB first, one bit per clock.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             c_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             p_bit;
    logic             g0_bit;
    logic             g1_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    // Shared slice: first half adder forms propagate/generate, second adds the carry.
    half_adder u_ha0 (
        .x(a_sh_reg[0]),
        .y(b_sh_reg[0]),
        .s(p_bit),
        .c(g0_bit)
    );

    half_adder u_ha1 (
        .x(p_bit),
        .y(c_reg),
        .s(s_bit),
        .c(g1_bit)
    );

    assign c_next   = g0_bit | g1_bit;
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    assign res_next = {s_bit, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            c_reg     <= 1'b0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        res_reg   <= '0;
                        c_reg     <= 1'b0;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    res_reg  <= res_next;
                    c_reg    <= c_next;
                    idx_reg  <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        sum_reg   <= res_next;
                        carry_reg <= c_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Start is deliberately ignored here; it is re-sampled in IDLE.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign carry = carry_reg;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: an 8-bit instance for most steps, a 4-bit one
// for the narrow-width case.

module tb_serial_add_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       carry8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       carry4;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .carry(carry8)
    );

    serial_add_sequencer #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .start(start4),
        .a    (a4),
        .b    (b4),
        .busy (busy4),
        .done (done4),
        .sum  (sum4),
        .carry(carry4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Launches one 8-bit op with a single-cycle start pulse and follows it back to IDLE.
    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, output int lat, output int bcnt);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat  = -1;
        bcnt = busy8 ? 1 : 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (busy8) bcnt++;
            if (done8 && lat < 0) lat = k;
            if (!busy8 && lat >= 0) break;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        int first_t;
        int last_t;
        int prev_t;
        logic [7:0] sum_at_done;
        logic       carry_at_done;

        rst = 1'b1;
        start8 = 1'b1;
        a8 = 8'h05;
        b8 = 8'h06;
        start4 = 1'b0;
        a4 = 4'h0;
        b4 = 4'h0;

        // 1. Reset held two cycles with start high
        tick();
        tick();
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_carry", carry8, 1'b0);
        rst = 1'b0;
        start8 = 1'b0;
        tick();
        check("rst_no_accept", busy8, 1'b0);
        $display("step1 reset: busy=%0b done=%0b sum=%02h carry=%0b", busy8, done8, sum8, carry8);

        // 2. 0F + 01
        run_op8(8'h0F, 8'h01, lat, bcnt);
        check("op1_latency", lat, 8);
        check("op1_busy_cycles", bcnt, 9);
        check("op1_sum", sum8, 8'h10);
        check("op1_carry", carry8, 1'b0);
        check("op1_done_low_after", done8, 1'b0);
        $display("step2 0F+01: lat=%0d busy=%0d sum=%02h carry=%0b", lat, bcnt, sum8, carry8);

        // 3. Overflow and alternating patterns
        run_op8(8'hFF, 8'h01, lat, bcnt);
        check("op2_latency", lat, 8);
        check("op2_sum", sum8, 8'h00);
        check("op2_carry", carry8, 1'b1);
        $display("step3 FF+01: lat=%0d sum=%02h carry=%0b", lat, sum8, carry8);
        run_op8(8'hAA, 8'h55, lat, bcnt);
        check("op3_sum", sum8, 8'hFF);
        check("op3_carry", carry8, 1'b0);
        $display("step3 AA+55: lat=%0d sum=%02h carry=%0b", lat, sum8, carry8);

        // 4. Start and operand changes while busy are ignored
        a8 = 8'h03;
        b8 = 8'h04;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'h12;
        b8 = 8'h34;
        check("op4_sum_held_in_run", sum8, 8'hFF);
        check("op4_busy_in_run", busy8, 1'b1);
        pulses = 0;
        sum_at_done = 8'h00;
        carry_at_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8) begin
                pulses++;
                sum_at_done = sum8;
                carry_at_done = carry8;
            end
        end
        check("op4_pulses", pulses, 1);
        check("op4_sum", sum_at_done, 8'h07);
        check("op4_carry", carry_at_done, 1'b0);
        check("op4_idle", busy8, 1'b0);
        $display("step4 03+04 w/ busy start: pulses=%0d sum=%02h carry=%0b", pulses, sum_at_done, carry_at_done);

        // 5. Reset mid-RUN aborts
        a8 = 8'h80;
        b8 = 8'h80;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_sum", sum8, 8'h00);
        check("abort_carry", carry8, 1'b0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8) pulses++;
        end
        check("abort_no_done", pulses, 0);
        $display("step5 abort: busy=%0b sum=%02h carry=%0b pulses=%0d", busy8, sum8, carry8, pulses);

        // 6. Back-to-back with start held high
        a8 = 8'h01;
        b8 = 8'h01;
        start8 = 1'b1;
        pulses = 0;
        first_t = -1;
        last_t = -1;
        prev_t = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (done8) begin
                pulses++;
                check("b2b_sum", sum8, 8'h02);
                if (prev_t >= 0) check("b2b_interval", k - prev_t, 10);
                if (first_t < 0) first_t = k;
                prev_t = k;
                last_t = k;
            end
        end
        start8 = 1'b0;
        check("b2b_first_latency", first_t, 9);
        check("b2b_pulses", pulses, 4);
        $display("step6 01+01 held: pulses=%0d first=%0d last=%0d", pulses, first_t, last_t);
        for (int k = 0; k < 12; k++) tick();

        // 6b. WIDTH=4: F + F
        a4 = 4'hF;
        b4 = 4'hF;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done4 && lat < 0) begin
                lat = k;
                break;
            end
        end
        check("w4_latency", lat, 4);
        check("w4_sum", sum4, 4'hE);
        check("w4_carry", carry4, 1'b1);
        $display("step6 w4 F+F: lat=%0d sum=%01h carry=%0b", lat, sum4, carry4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
